bitvault_cmd_ctrl: RTL and testbench
====================================

# bitvault_cmd_ctrl

Byte-stream command controller that sits directly upstream of the BitVault 4x8 register file. It parses 1- and 2-byte command frames from a valid/ready byte source and drives the register file's write port (rf_we/rf_waddr/rf_wdata). It serves READ commands through the read port (rf_raddr/rf_rdata) and returns the result on a valid/ready response stream. It flags malformed or stalled frames.

## Interface
- TIMEOUT, 16: idle cycles allowed between a WRITE command byte and its data byte before the frame is aborted (range 1..255).
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  command/data byte available.
- in_data  in  8  command/data byte.
- in_ready  out  1  controller accepts byte; transfer occurs when in_valid & in_ready at a rising edge.
- out_valid  out  1  response byte available.
- out_data  out  8  response byte (register contents).
- out_ready  in  1  sink accepts response.
- rf_we  out  1  register-file write enable (single-cycle pulse).
- rf_waddr  out  2  register-file write address.
- rf_wdata  out  8  register-file write data.
- rf_raddr  out  2  register-file read address.
- rf_rdata  in  8  register-file combinational read data.
- err  out  1  one-cycle pulse on a protocol error.
- err_count  out  8  saturating count of errors.

## Operation
- Command byte: [7:6] opcode (00 NOP, 01 WRITE, 10 READ, 11 illegal); [5:2] reserved, must be 0; [1:0] register address.
- Error conditions: illegal opcode or nonzero reserved bits. The byte is consumed and dropped, err pulses, and the state stays IDLE.
- FSM states: IDLE, WDATA, WRITE, RD, RESP.
- IDLE: accept a byte.
  - NOP: stay in IDLE.
  - WRITE: latch the address and go to WDATA.
  - READ: latch the address into rf_raddr and go to RD.
- WDATA: accept the data byte, latch it into rf_wdata, and go to WRITE.
  - The timeout counter clears on entry and increments on each cycle with no transfer.
  - When the counter reaches TIMEOUT: pulse err and return to IDLE; no write occurs.
- WRITE: rf_we=1 for exactly this cycle, with rf_waddr/rf_wdata stable; go to IDLE.
- RD: rf_raddr is stable; capture rf_rdata into out_data, set out_valid, and go to RESP.
- RESP: hold out_valid and out_data until out_ready=1 at an edge; then clear out_valid and go to IDLE.
- in_ready is registered and equals 1 iff the next state is IDLE or WDATA. It is 0 in WRITE, RD and RESP.
- Data bytes in WDATA are never decoded as commands, including 0xC0 and other illegal patterns.
- rf_waddr, rf_wdata and rf_raddr hold their last values when not in use.
- err_count increments on each err pulse and saturates at 255.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, rf_we=0, rf_waddr=0, rf_wdata=0, rf_raddr=0, err=0, err_count=0. State resets to IDLE.
- After reset release, in_ready=1 from the first rising edge.
- Write latency: data byte accepted at edge N; rf_we is high from edge N to edge N+1, so the register file updates at edge N+1.
- Earliest next command acceptance after a write is edge N+2.
- Read latency: READ accepted at edge N; rf_data is sampled and out_valid rises at edge N+1.
- Back-to-back throughput:
  - WRITE frame: 3 cycles.
  - READ: 3 cycles with out_ready held at 1.
- Read-after-write to the same address returns the new value, with no bypass needed.
- Response backpressure: out_valid and out_data stay stable while out_ready=0, for any number of cycles.
- Reset mid-frame, in any state: the frame is discarded immediately, rf_we drops, out_valid drops, and no write completes.

## Test plan
- Reset, then WRITE 0x41 followed by 0xA5 -> one rf_we pulse with waddr=1, wdata=0xA5. Then READ 0x81 -> out_data=0xA5 one cycle after acceptance.
- Write regs 0..3 with 0x11/0x22/0x33/0x44, then read all four with out_ready=0 for 5 cycles per response -> values returned in order, stable while stalled, in_ready=0 throughout the stall.
- Illegal bytes 0xC2 and 0x44 -> err pulses twice, err_count=2, no rf_we. A following NOP 0x00 -> no error and no output.
- WRITE 0x42 then in_valid=0 for TIMEOUT cycles -> err pulse and return to IDLE. Next byte 0x05 is treated as a command, not data, so no write occurs.
- WRITE 0x43 with data 0xFF, then assert rst_n=0 during the WRITE cycle -> all outputs return to reset values. Subsequent READ 0x83 returns the register-file reset value 0x00.
- 260 illegal bytes -> err_count saturates at 255.

Source files
------------

// File: rtl/bitvault_cmd_ctrl.sv
// Command controller for the BitVault 4x8 register file: parses 1/2-byte
// frames from a byte stream, drives the write/read ports, returns read data.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for a command byte
// S_WDATA | WRITE command taken, waiting (with timeout) for data byte
// S_WRITE | single-cycle register-file write strobe
// S_RD    | read address presented, capture rf_rdata
// S_RESP  | response held on out_* until the sink accepts it
module bitvault_cmd_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       rf_we,
  output logic [1:0] rf_waddr,
  output logic [7:0] rf_wdata,
  output logic [1:0] rf_raddr,
  input  logic [7:0] rf_rdata,
  output logic       err,
  output logic [7:0] err_count
);

  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_WRITE,
    S_RD,
    S_RESP
  } state_t;

  state_t     state, state_nxt;
  logic       xfer;
  logic       cmd_bad;
  logic       err_nxt;
  logic       waddr_ld;
  logic       wdata_ld;
  logic       raddr_ld;
  logic       rd_cap;
  logic       resp_done;
  logic       tmo_run;
  logic [7:0] tmo_cnt;

  assign xfer    = in_valid & in_ready;
  assign cmd_bad = (in_data[7:6] == 2'b11) || (in_data[5:2] != 4'd0);

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    waddr_ld  = 1'b0;
    wdata_ld  = 1'b0;
    raddr_ld  = 1'b0;
    rd_cap    = 1'b0;
    resp_done = 1'b0;
    tmo_run   = 1'b0;
    case (state)
      S_IDLE: begin
        if (xfer) begin
          if (cmd_bad) begin
            err_nxt = 1'b1;
          end else begin
            case (in_data[7:6])
              2'b01: begin
                state_nxt = S_WDATA;
                waddr_ld  = 1'b1;
              end
              2'b10: begin
                state_nxt = S_RD;
                raddr_ld  = 1'b1;
              end
              default: state_nxt = S_IDLE;
            endcase
          end
        end
      end
      S_WDATA: begin
        if (xfer) begin
          wdata_ld  = 1'b1;
          state_nxt = S_WRITE;
        end else begin
          tmo_run = 1'b1;
          // count of 1 means this idle edge is the last one allowed
          if (tmo_cnt == 8'd1) begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_WRITE: state_nxt = S_IDLE;
      S_RD: begin
        rd_cap    = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        if (out_ready) begin
          resp_done = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      rf_we     <= 1'b0;
      rf_waddr  <= 2'd0;
      rf_wdata  <= 8'd0;
      rf_raddr  <= 2'd0;
      err       <= 1'b0;
      err_count <= 8'd0;
      tmo_cnt   <= 8'd0;
    end else begin
      in_ready <= (state_nxt == S_IDLE) || (state_nxt == S_WDATA);
      rf_we    <= (state_nxt == S_WRITE);
      err      <= err_nxt;
      if (err_nxt && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      if (waddr_ld) rf_waddr <= in_data[1:0];
      if (wdata_ld) rf_wdata <= in_data;
      if (raddr_ld) rf_raddr <= in_data[1:0];
      if (waddr_ld)     tmo_cnt <= TMO_LOAD;
      else if (tmo_run) tmo_cnt <= tmo_cnt - 8'd1;
      if (rd_cap) begin
        out_data  <= rf_rdata;
        out_valid <= 1'b1;
      end else if (resp_done) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitvault_cmd_ctrl.sv
// Directed bench for bitvault_cmd_ctrl with a behavioural 4x8 register file.
module tb_bitvault_cmd_ctrl;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       rf_we;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [1:0] rf_raddr;
  logic [7:0] rf_rdata;
  logic       err;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int we_count = 0;

  logic [7:0] rf_mem [4];
  logic [7:0] exp_v  [4];

  always #5 clk = ~clk;

  bitvault_cmd_ctrl #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .err       (err),
    .err_count (err_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) rf_mem[k] <= 8'd0;
    end else if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end
  assign rf_rdata = rf_mem[rf_raddr];

  always @(posedge clk) begin
    if (rf_we === 1'b1) we_count <= we_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the transfer edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    send_byte({6'b010000, a});
    send_byte(d);
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("resp_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic read_reg(input logic [1:0] a, input logic [7:0] d, input string tag);
    send_byte({6'b100000, a});
    wait_resp();
    chk(tag, 32'(out_data), 32'(d));
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b1;
    exp_v     = '{8'h11, 8'h22, 8'h33, 8'h44};

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_rf_we",     32'(rf_we),     32'd0);
    chk("rst_waddr",     32'(rf_waddr),  32'd0);
    chk("rst_wdata",     32'(rf_wdata),  32'd0);
    chk("rst_raddr",     32'(rf_raddr),  32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 32'(in_ready), 32'd1);

    // write 0xA5 to reg 1 with exact cycle timing, then read it back
    in_valid = 1'b1;
    in_data  = 8'h41;
    @(negedge clk);
    chk("wdata_rdy", 32'(in_ready), 32'd1);
    in_data = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    chk("we_pulse",     32'(rf_we),    32'd1);
    chk("we_addr",      32'(rf_waddr), 32'd1);
    chk("we_data",      32'(rf_wdata), 32'hA5);
    chk("write_nrdy",   32'(in_ready), 32'd0);
    chk("we_cnt_pre",   32'(we_count), 32'd0);
    @(negedge clk);
    chk("we_drop",      32'(rf_we),    32'd0);
    chk("we_cnt_1",     32'(we_count), 32'd1);
    chk("rdy_post_wr",  32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h81;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rd_not_yet",   32'(out_valid), 32'd0);
    chk("rd_raddr",     32'(rf_raddr),  32'd1);
    chk("rd_nrdy",      32'(in_ready),  32'd0);
    @(negedge clk);
    chk("rd_valid",     32'(out_valid), 32'd1);
    chk("rd_data_a5",   32'(out_data),  32'hA5);
    @(negedge clk);
    chk("rd_clear",     32'(out_valid), 32'd0);
    chk("rd_rdy_back",  32'(in_ready),  32'd1);

    // four writes, then stalled reads
    for (int i = 0; i < 4; i++) write_reg(2'(i), exp_v[i]);
    @(negedge clk);
    chk("we_cnt_5", 32'(we_count), 32'd5);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_byte({6'b100000, 2'(i)});
      wait_resp();
      chk("stall_data", 32'(out_data), 32'(exp_v[i]));
      repeat (5) begin
        @(negedge clk);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold",  32'(out_data),  32'(exp_v[i]));
        chk("stall_nrdy",  32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("stall_release", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
    end
    out_ready = 1'b1;

    // illegal commands, then a NOP
    send_byte(8'hC2);
    chk("err_c2", 32'(err), 32'd1);
    send_byte(8'h44);
    chk("err_44", 32'(err), 32'd1);
    chk("err_count_2", 32'(err_count), 32'd2);
    send_byte(8'h00);
    chk("nop_no_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    chk("nop_no_out", 32'(out_valid), 32'd0);
    chk("nop_cnt",    32'(err_count), 32'd2);
    chk("err_no_we",  32'(we_count),  32'd5);

    // data-byte timeout
    send_byte(8'h42);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_not_yet",  32'(err),      32'd0);
    chk("tmo_wait_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("tmo_err",       32'(err),       32'd1);
    chk("tmo_err_count", 32'(err_count), 32'd3);
    send_byte(8'h05);
    chk("tmo_next_cmd", 32'(err),       32'd1);
    chk("tmo_cnt_4",    32'(err_count), 32'd4);
    @(negedge clk);
    chk("tmo_no_write", 32'(we_count),  32'd5);

    // reset during the write strobe
    write_reg(2'd3, 8'hFF);
    chk("mid_we", 32'(rf_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we",    32'(rf_we),     32'd0);
    chk("mid_rst_rdy",   32'(in_ready),  32'd0);
    chk("mid_rst_wdata", 32'(rf_wdata),  32'd0);
    chk("mid_rst_waddr", 32'(rf_waddr),  32'd0);
    chk("mid_rst_ovld",  32'(out_valid), 32'd0);
    chk("mid_rst_ecnt",  32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_nowr", 32'(we_count), 32'd5);
    read_reg(2'd3, 8'h00, "rd_after_rst");

    // illegal-looking data byte is plain data
    write_reg(2'd2, 8'hC0);
    chk("data_c0_no_err", 32'(err), 32'd0);
    read_reg(2'd2, 8'hC0, "rd_c0");
    chk("data_c0_ecnt", 32'(err_count), 32'd0);

    // err_count saturation
    for (int i = 0; i < 254; i++) send_byte(8'hC3);
    chk("sat_254", 32'(err_count), 32'd254);
    send_byte(8'hC3);
    chk("sat_255", 32'(err_count), 32'd255);
    for (int i = 0; i < 5; i++) send_byte(8'hC3);
    chk("sat_hold", 32'(err_count), 32'd255);
    chk("sat_err",  32'(err),       32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
